mul_div_iter: RTL and testbench

- Parametrised, multi-cycle successor to the combinational M-extension unit. Executes all eight RV32M-style operations (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with a radix-2 iterative datapath.
- Uses valid/ready handshakes on both request and response, so the core can stall on it.
- Handles RISC-V divide-by-zero and signed-overflow corner cases explicitly.
- Returns the correct high product word for every mulh variant.

---
 rtl/mul_div_iter.sv | 164 ++++++++++++++++
 tb/tb_mul_div_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_iter.sv
// Radix-2 iterative RV32M-style multiply/divide unit with valid/ready handshakes.
// One multiplier/quotient bit per cycle; special cases bypass the iteration.
module mul_div_iter #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      multControl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] multResult,
    output logic            illegal,
    output logic            busy
);

    localparam logic [4:0] OP_MUL    = 5'h0A;
    localparam logic [4:0] OP_MULH   = 5'h0B;
    localparam logic [4:0] OP_MULHSU = 5'h0C;
    localparam logic [4:0] OP_MULHU  = 5'h0D;
    localparam logic [4:0] OP_DIV    = 5'h0E;
    localparam logic [4:0] OP_DIVU   = 5'h0F;
    localparam logic [4:0] OP_REM    = 5'h10;
    localparam logic [4:0] OP_REMU   = 5'h11;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state;
    logic [4:0]          op;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     opd;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     rem;
    logic [CNT_W-1:0]    cnt;

    logic                op_legal, is_div, signed_a, signed_b, a_neg, b_neg;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     a_mag, b_mag;

    always_comb begin
        op_legal = (multControl >= OP_MUL) && (multControl <= OP_REMU);
        is_div   = (multControl >= OP_DIV) && (multControl <= OP_REMU);
        signed_a = (multControl == OP_MULH) || (multControl == OP_MULHSU) ||
                   (multControl == OP_DIV)  || (multControl == OP_REM);
        signed_b = (multControl == OP_MULH) || (multControl == OP_DIV) ||
                   (multControl == OP_REM);
        a_neg    = signed_a && A[XLEN-1];
        b_neg    = signed_b && B[XLEN-1];
        a_mag    = a_neg ? (~A + 1'b1) : A;
        b_mag    = b_neg ? (~B + 1'b1) : B;
        div_zero = is_div && (B == '0);
        div_ovf  = ((multControl == OP_DIV) || (multControl == OP_REM)) &&
                   (A == MOST_NEG) && (B == '1);
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in.
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo_v, rem_v;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        rem_sh  = {rem, acc[XLEN-1]};
        trial   = rem_sh - {1'b0, opd};
        prod    = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
        quo_v   = (neg_a ^ neg_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem_v   = neg_a ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            multResult <= '0;
            illegal    <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            op         <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            opd        <= '0;
            acc        <= '0;
            rem        <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        op       <= multControl;
                        illegal  <= !op_legal;
                        if (!op_legal) begin
                            multResult <= '0;
                            out_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else if (div_zero) begin
                            multResult <= ((multControl == OP_DIV) || (multControl == OP_DIVU)) ? '1 : A;
                            out_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else if (div_ovf) begin
                            multResult <= (multControl == OP_DIV) ? A : '0;
                            out_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            neg_a <= a_neg;
                            neg_b <= b_neg;
                            opd   <= is_div ? b_mag : a_mag;
                            acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            rem   <= '0;
                            cnt   <= CNT_W'(XLEN - 1);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op >= OP_DIV) begin
                        if (!trial[XLEN]) begin
                            rem <= trial[XLEN-1:0];
                            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    unique case (op)
                        OP_MUL:                        multResult <= prod[XLEN-1:0];
                        OP_MULH, OP_MULHSU, OP_MULHU:  multResult <= prod[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU:               multResult <= quo_v;
                        default:                       multResult <= rem_v;
                    endcase
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_iter.sv
// Self-checking bench for mul_div_iter: directed vectors with literal results,
// plus a queue-based arithmetic model compared against the DUT on every cycle.
module tb_mul_div_iter;

    localparam int XLEN = 32;
    localparam logic [4:0] OP_MUL = 5'h0A, OP_MULH = 5'h0B, OP_MULHSU = 5'h0C, OP_MULHU = 5'h0D;
    localparam logic [4:0] OP_DIV = 5'h0E, OP_DIVU = 5'h0F, OP_REM = 5'h10, OP_REMU = 5'h11;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  multControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] multResult;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    mul_div_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .multControl(multControl), .A(A), .B(B), .out_valid(out_valid),
        .out_ready(out_ready), .multResult(multResult), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: 64-bit products and native truncating division.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        exp_t               e;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.ill = 1'b0;
        e.res = '0;
        case (op)
            OP_MUL:    begin up = ua * ub;           e.res = up[31:0];  end
            OP_MULH:   begin sp = sa * sb;           e.res = sp[63:32]; end
            OP_MULHSU: begin sp = sa * $signed(ub);  e.res = sp[63:32]; end
            OP_MULHU:  begin up = ua * ub;           e.res = up[63:32]; end
            OP_DIV: begin
                if (b == 0)                                    e.res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
                else begin sp = sa / sb; e.res = sp[31:0]; end
            end
            OP_REM: begin
                if (b == 0)                                    e.res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'h0;
                else begin sp = sa % sb; e.res = sp[31:0]; end
            end
            OP_DIVU: begin
                if (b == 0) e.res = 32'hFFFF_FFFF;
                else begin up = ua / ub; e.res = up[31:0]; end
            end
            OP_REMU: begin
                if (b == 0) e.res = a;
                else begin up = ua % ub; e.res = up[31:0]; end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < OP_MUL || op > OP_REMU) return 1;
        if (op >= OP_DIV && b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: push on accept, pop on response handshake, cleared by reset.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(multControl, A, B));
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(q.size() == 0));
            check("busy", 32'(busy), 32'(q.size() != 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_response: got out_valid=1, expected no response at %0t", $time);
                end else begin
                    check("result", multResult, q[0].res);
                    check("illegal", 32'(illegal), 32'(q[0].ill));
                end
            end
        end
    end

    // Stimulus is applied 2 time units after each rising edge.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit lit, input logic [31:0] exp_res,
                          input bit exp_ill, input bit poke, input string name);
        int lat;
        int guard;
        multControl = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        @(posedge clk); #2;
        in_valid    = 1'b0;
        A           = $urandom;
        B           = $urandom;
        multControl = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (poke && lat == 5) begin
                multControl = OP_MUL;
                in_valid    = 1'b1;
            end
            if (poke && lat == 9) in_valid = 1'b0;
            @(posedge clk); #2;
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
        if (lit) begin
            check({name, "_value"}, multResult, exp_res);
            check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
        end
        repeat (hold) begin
            @(posedge clk); #2;
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'h0);
            if (lit) check({name, "_hold_value"}, multResult, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        check({name, "_released"}, 32'(out_valid), 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the end, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multControl = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_result", multResult, 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        reset = 1'b0;
        @(posedge clk); #2;

        e = model(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("model_mulhsu", e.res, 32'hFFFF_FFFF);
        e = model(OP_REM, 32'hFFFF_FFF9, 32'h2);
        check("model_rem", e.res, 32'hFFFF_FFFF);

        run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0001, 0, 0, "mul_m1");
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 0, 0, "mulh_m1");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 0, 0, "mulhu_m1");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 0, 0, "mulhsu_m1");
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'h2, 0, 1, 32'hFFFF_FFFD, 0, 0, "div_m7");
        run_op(OP_REM,    32'hFFFF_FFF9, 32'h2, 0, 1, 32'hFFFF_FFFF, 0, 0, "rem_m7");
        run_op(OP_DIVU,   32'hFFFF_FFF9, 32'h2, 0, 1, 32'h7FFF_FFFC, 0, 0, "divu_m7");
        run_op(OP_REMU,   32'hFFFF_FFF9, 32'h2, 0, 1, 32'h0000_0001, 0, 0, "remu_m7");
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 0, 0, "div_ovf");
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0000_0000, 0, 0, "rem_ovf");
        run_op(OP_DIV,    32'h0000_1234, 32'h0, 0, 1, 32'hFFFF_FFFF, 0, 0, "div_zero");
        run_op(OP_REMU,   32'h0000_1234, 32'h0, 0, 1, 32'h0000_1234, 0, 0, "remu_zero");
        run_op(OP_REM,    32'hFFFF_FF00, 32'h0, 0, 1, 32'hFFFF_FF00, 0, 0, "rem_zero");
        run_op(5'h05,     32'h1234_5678, 32'h9, 0, 1, 32'h0, 1, 0, "illegal_05");
        run_op(5'h09,     32'h1, 32'h1, 0, 1, 32'h0, 1, 0, "illegal_09");
        run_op(5'h12,     32'h1, 32'h1, 0, 1, 32'h0, 1, 0, "illegal_12");
        run_op(OP_MUL,    32'h1234_5678, 32'h0, 0, 1, 32'h0, 0, 0, "mul_zero");
        run_op(OP_MUL,    32'h0001_0003, 32'h0002_0005, 0, 1, 32'h000B_000F, 0, 0, "mul_small");
        run_op(OP_MULHU,  32'h0001_0000, 32'h0003_0000, 5, 1, 32'h0000_0003, 0, 0, "hold5");
        run_op(OP_DIVU,   32'd100, 32'd7, 0, 1, 32'd14, 0, 1, "busy_poke");

        // Abort a divide mid-iteration; the scoreboard rejects any later response.
        multControl = OP_DIV; A = 32'd1000; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'h1);
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("abort_no_response", 32'(out_valid), 32'h0);

        for (int op = OP_MUL; op <= OP_REMU; op++) begin
            for (int n = 0; n < 20; n++) begin
                run_op(5'(op), pick(), pick(), $urandom_range(0, 2), 0, 32'h0, 0, 0, "rand");
            end
        end
        for (int n = 0; n < 8; n++) begin
            run_op(5'($urandom_range(18, 31)), $urandom, $urandom, 0, 0, 32'h0, 0, 0, "rand_illegal");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
